// File: rtl/mem_byte_access_pkg.sv
// Shared types for the byte-serial MEM-stage access unit: stall codes,
// RISC-V load/store funct3 encodings and the access FSM state encoding.
package mem_byte_access_pkg;

  typedef enum logic [1:0] {
    STALL_PASS = 2'b00,
    STALL_HOLD = 2'b01,
    STALL_BUBB = 2'b10
  } stall_code_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_TAIL = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Access width in bytes from funct3[1:0]; the reserved 2'b11 is treated as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
module mem_load_ext
  import mem_byte_access_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    case (funct3)
      F3_LB:   rdata = {{24{data[7]}}, data[7:0]};
      F3_LH:   rdata = {{16{data[15]}}, data[15:0]};
      F3_LBU:  rdata = {24'h0, data[7:0]};
      F3_LHU:  rdata = {16'h0, data[15:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/mem_byte_access.sv
// MEM-stage adapter that serialises LB/LH/LW/SB/SH/SW onto a byte-wide RAM
// with one-cycle read latency, stalling the pipeline until the access is done.
module mem_byte_access
  import mem_byte_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        stall_mem,
  output logic        done,
  output logic [31:0] rdata
);

  state_e      state_q, state_d;
  logic        load_q, load_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;

  logic        accept;
  logic [1:0]  cap_idx;
  logic [31:0] ext_rdata;
  stall_code_e stall_code;

  assign accept = (state_q == S_IDLE) && req_valid && (req_load || req_store);

  // Read data lags mem_a by a cycle, so BUSY step k stores byte k-1 and TAIL stores byte n-1.
  assign cap_idx = (state_q == S_TAIL) ? (n_q[1:0] - 2'd1) : (k_q[1:0] - 2'd1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d  = state_q;
    load_d   = load_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    n_d      = n_q;
    k_d      = k_q;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          load_d   = req_load;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          n_d      = byte_count(req_funct3[1:0]);
          k_d      = 3'd0;
          data_d   = '0;
        end
      end
      S_BUSY: begin
        mem_a = addr_q + {29'd0, k_q};
        if (!load_q) begin
          mem_wr   = 1'b1;
          mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
        end else if (k_q != 3'd0) begin
          data_d[{cap_idx, 3'b000} +: 8] = mem_din;
        end
        k_d = k_q + 3'd1;
        if (k_q == n_q - 3'd1) state_d = load_q ? S_TAIL : S_DONE;
      end
      S_TAIL: begin
        data_d[{cap_idx, 3'b000} +: 8] = mem_din;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  mem_load_ext u_ext (
    .data   (data_d),
    .funct3 (funct3_q),
    .rdata  (ext_rdata)
  );

  assign rdata_d = (state_q == S_TAIL) ? ext_rdata : rdata_q;

  always_comb begin
    stall_code = STALL_PASS;
    if (accept || state_q == S_BUSY || state_q == S_TAIL) stall_code = STALL_HOLD;
  end

  assign stall_mem = (stall_code != STALL_PASS);
  assign done      = (state_q == S_DONE);
  assign rdata     = rdata_q;

  // NOTE: reset is synchronous, so it is sampled inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      load_q   <= load_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      n_q      <= n_d;
      k_q      <= k_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_access.sv
// Self-checking bench for mem_byte_access: directed vector table, reset-abort and
// back-to-back sequences, then random traffic against a byte-array reference model.
module tb_mem_byte_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr, stall_mem, done;
  logic [31:0] rdata;

  mem_byte_access dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_din    (mem_din),
    .mem_a      (mem_a),
    .mem_dout   (mem_dout),
    .mem_wr     (mem_wr),
    .stall_mem  (stall_mem),
    .done       (done),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  wr_t         wr_log[$];
  logic [31:0] pend_a = '0;
  logic [31:0] exp_rdata = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Byte-wide RAM: writes land at the negedge, reads return one cycle after the address.
  always @(negedge clk) begin
    pend_a = mem_a;
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wr_log.push_back('{a: mem_a, d: mem_dout});
    end
  end

  always @(posedge clk) begin
    #1;
    mem_din = ram_rd(pend_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Presents one request at the current cycle and holds it until done is seen;
  // returns one cycle after DONE with the request still driven.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, lat, cyc, n_wr;
    bit got_done, stall_ok;
    logic [31:0] exp_rd;
    n      = nbytes(f3);
    lat    = ld ? n + 2 : n + 1;
    exp_rd = ld ? ref_load(f3, a) : exp_rdata;
    wr_log.delete();
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; got_done = 0; stall_ok = 1;
    while (cyc < 20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
      if (stall_mem !== 1'b1) stall_ok = 0;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("stall_until_done", 32'(stall_ok), 32'd1);
    check("stall_at_done", 32'(stall_mem), 32'd0);
    check("bus_idle_at_done", 32'(mem_a == 0 && mem_dout == 0 && mem_wr == 0), 32'd1);
    check("rdata", rdata, exp_rd);
    n_wr = ld ? 0 : n;
    check("write_count", 32'(wr_log.size()), 32'(n_wr));
    for (int i = 0; i < n_wr && i < wr_log.size(); i++) begin
      check("write_addr", wr_log[i].a, a + 32'(i));
      check("write_byte", 32'(wr_log[i].d), 32'(wd[8*i +: 8]));
    end
    if (!ld) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    exp_rdata = exp_rd;
    @(posedge clk); #1;
  endtask

  task automatic idle_noop();
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0;
    @(negedge clk);
    check("noop_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("noop_no_state_change", 32'({stall_mem, done, mem_wr}), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    bit quiet_ok;
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_din = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 32'({stall_mem, done, mem_wr}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h84);
    poke(32'h007, 8'h80);
    vecs[0] = '{ld: 1, st: 0, f3: 3'b010, addr: 32'h0000_0100, wdata: 32'h0, exp_rdata: 32'h8433_2211};
    vecs[1] = '{ld: 1, st: 0, f3: 3'b000, addr: 32'h0000_0007, wdata: 32'h0, exp_rdata: 32'hFFFF_FF80};
    vecs[2] = '{ld: 1, st: 1, f3: 3'b100, addr: 32'h0000_0007, wdata: 32'hFFFF_FFFF, exp_rdata: 32'h0000_0080};
    vecs[3] = '{ld: 0, st: 1, f3: 3'b001, addr: 32'h0000_0201, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0000_0080};
    vecs[4] = '{ld: 0, st: 1, f3: 3'b010, addr: 32'hFFFF_FFFE, wdata: 32'h1234_5678, exp_rdata: 32'h0000_0080};
    vecs[5] = '{ld: 1, st: 0, f3: 3'b010, addr: 32'hFFFF_FFFE, wdata: 32'h0, exp_rdata: 32'h1234_5678};
    vecs[6] = '{ld: 1, st: 0, f3: 3'b001, addr: 32'h0000_0201, wdata: 32'h0, exp_rdata: 32'hFFFF_BEEF};
    vecs[7] = '{ld: 1, st: 0, f3: 3'b101, addr: 32'h0000_0201, wdata: 32'h0, exp_rdata: 32'h0000_BEEF};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      check("table_rdata", rdata, vecs[i].exp_rdata);
      idle_noop();
    end

    // Reset two cycles into a word store: only the first two bytes may reach the RAM.
    wr_log.delete();
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    quiet_ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (mem_wr !== 1'b0 || done !== 1'b0 || stall_mem !== 1'b0) quiet_ok = 0;
      @(posedge clk); #1;
    end
    check("abort_quiet", 32'(quiet_ok), 32'd1);
    check("abort_write_count", 32'(wr_log.size()), 32'd2);
    check("abort_rdata", rdata, 32'd0);
    ref_mem[32'h300] = 8'h0D; ref_mem[32'h301] = 8'hF0;
    exp_rdata = '0;
    run_op(1, 0, 3'b010, 32'h300, 32'h0);
    check("abort_readback", rdata, 32'h0000_F00D);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // LH then SB presented in the cycle right after DONE.
    poke(32'h500, 8'h34); poke(32'h501, 8'h92);
    run_op(1, 0, 3'b001, 32'h500, 32'h0);
    check("b2b_lh", rdata, 32'hFFFF_9234);
    run_op(0, 1, 3'b000, 32'h508, 32'h0000_00A5);
    check("b2b_sb_rdata_kept", rdata, 32'hFFFF_9234);
    req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      int gap;
      logic [2:0] ld_f3 [6];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = ld ? ld_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                       : 32'h400 + 32'($urandom_range(0, 63));
      run_op(ld, st, f3, a, $urandom);
      gap = $urandom_range(0, 2);
      if (gap == 1) idle_noop();
      else if (gap == 2) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
